exe2mem: RTL and testbench

EXE2MEM -- requirements
Module: exe2mem

---
 rtl/exe2mem.sv | 119 +++++++++++
 tb/tb_exe2mem.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe2mem.sv
// rtl/exe2mem.sv - EXE-to-MEM result buffer with head-entry bypass
//
// Purpose: buffers up to DEPTH execute-stage results for the MEM stage.
// The oldest entry (head) is presented combinationally from storage, and its
// result is forwarded to decode when it is a non-load write to a nonzero
// register.
//
// Ports:
//   CLK, RESET            clock; synchronous active-high reset
//   EXE_VALID_SE          push request for the current ALU result
//   RES_SE, DEST_SE       ALU result and destination register index
//   WB_SE                 result is written back
//   MEM_LOAD_SE/STORE_SE  memory operation type (both high is legal)
//   MEM_DATA_SE/SIZE_SE   store data and access size
//   FLUSH_SE              discard every buffered entry
//   MEM_POP_SM            MEM stage consumes the head entry
//   EXE2MEM_READY_SE      buffer can accept a push
//   EXE2MEM_EMPTY_SE      no entry buffered
//   *_RE                  head-entry fields (all zero when empty)
//   BP_VALID/DEST/DATA_RE forwarding of the head result to decode

module exe2mem #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EXE_VALID_SE,
  input  logic [31:0] RES_SE,
  input  logic [5:0]  DEST_SE,
  input  logic        WB_SE,
  input  logic        MEM_LOAD_SE,
  input  logic        MEM_STORE_SE,
  input  logic [31:0] MEM_DATA_SE,
  input  logic [1:0]  MEM_SIZE_SE,
  input  logic        FLUSH_SE,
  input  logic        MEM_POP_SM,
  output logic        EXE2MEM_READY_SE,
  output logic        EXE2MEM_EMPTY_SE,
  output logic [31:0] RES_RE,
  output logic [5:0]  DEST_RE,
  output logic        WB_RE,
  output logic        MEM_LOAD_RE,
  output logic        MEM_STORE_RE,
  output logic [31:0] MEM_DATA_RE,
  output logic [1:0]  MEM_SIZE_RE,
  output logic        BP_VALID_RE,
  output logic [5:0]  BP_DEST_RE,
  output logic [31:0] BP_DATA_RE
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Entry layout: {RES, DEST, WB, LOAD, STORE, MEM_DATA, MEM_SIZE}
  localparam int EW = 32 + 6 + 1 + 1 + 1 + 32 + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          empty;
  logic          ready;
  logic          push_en;
  logic          pop_en;
  logic [EW-1:0] head;

  // Both flags come from the registered count only, so READY cannot be
  // raised by a same-cycle pop and there is no input-to-output path.
  assign empty = (count == '0);
  assign ready = (count != CW'(DEPTH));

  assign push_en = EXE_VALID_SE && ready && !FLUSH_SE && !RESET;
  assign pop_en  = MEM_POP_SM && !empty && !FLUSH_SE && !RESET;

  // Pointer and occupancy state. DEPTH is a power of two, so the pointers
  // wrap from DEPTH-1 to 0 by natural overflow.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH_SE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; stale contents are hidden by the empty gating.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      mem[wr_ptr] <= {RES_SE, DEST_SE, WB_SE, MEM_LOAD_SE, MEM_STORE_SE,
                      MEM_DATA_SE, MEM_SIZE_SE};
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

  assign EXE2MEM_READY_SE = ready;
  assign EXE2MEM_EMPTY_SE = empty;

  assign {RES_RE, DEST_RE, WB_RE, MEM_LOAD_RE, MEM_STORE_RE,
          MEM_DATA_RE, MEM_SIZE_RE} = head;

  // Loads have no result yet and r0 is never written, so neither forwards.
  // WB_RE is already zero when empty; the explicit term keeps intent clear.
  assign BP_VALID_RE = !empty && WB_RE && !MEM_LOAD_RE && (DEST_RE != 6'd0);
  assign BP_DEST_RE  = BP_VALID_RE ? DEST_RE : 6'd0;
  assign BP_DATA_RE  = BP_VALID_RE ? RES_RE : 32'd0;

endmodule

// File: tb/tb_exe2mem.sv
// tb/tb_exe2mem.sv - scoreboard bench for exe2mem
module tb_exe2mem;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  dest;
    logic        wb;
    logic        ld;
    logic        st;
    logic [31:0] md;
    logic [1:0]  sz;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] res_in;
  logic [5:0]  dest_in;
  logic        wb_in;
  logic        ld_in;
  logic        st_in;
  logic [31:0] md_in;
  logic [1:0]  sz_in;
  logic        flush;
  logic        pop;
  logic        ready_o;
  logic        empty_o;
  logic [31:0] res_o;
  logic [5:0]  dest_o;
  logic        wb_o;
  logic        ld_o;
  logic        st_o;
  logic [31:0] md_o;
  logic [1:0]  sz_o;
  logic        bpv_o;
  logic [5:0]  bpd_o;
  logic [31:0] bpdata_o;

  exe2mem #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET(rst), .EXE_VALID_SE(valid), .RES_SE(res_in),
    .DEST_SE(dest_in), .WB_SE(wb_in), .MEM_LOAD_SE(ld_in),
    .MEM_STORE_SE(st_in), .MEM_DATA_SE(md_in), .MEM_SIZE_SE(sz_in),
    .FLUSH_SE(flush), .MEM_POP_SM(pop), .EXE2MEM_READY_SE(ready_o),
    .EXE2MEM_EMPTY_SE(empty_o), .RES_RE(res_o), .DEST_RE(dest_o),
    .WB_RE(wb_o), .MEM_LOAD_RE(ld_o), .MEM_STORE_RE(st_o),
    .MEM_DATA_RE(md_o), .MEM_SIZE_RE(sz_o), .BP_VALID_RE(bpv_o),
    .BP_DEST_RE(bpd_o), .BP_DATA_RE(bpdata_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   mcount = 0;
  bit   mon_en = 0;
  ent_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] r, input logic [5:0] d,
                              input logic w, input logic l, input logic s,
                              input logic [31:0] m, input logic [1:0] z);
    ent_t e;
    e.res = r; e.dest = d; e.wb = w; e.ld = l; e.st = s; e.md = m; e.sz = z;
    return e;
  endfunction

  // Drive one cycle of inputs, then advance the reference model at the edge.
  task automatic step(input ent_t e, input logic v, input logic p,
                      input logic f, input logic r);
    bit acc;
    bit pk;
    valid = v; pop = p; flush = f; rst = r;
    res_in = e.res; dest_in = e.dest; wb_in = e.wb; ld_in = e.ld;
    st_in = e.st; md_in = e.md; sz_in = e.sz;
    @(posedge clk);
    if (r || f) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      acc = v && (mcount < DEPTH);
      pk  = p && (mcount > 0);
      if (acc) exp_q.push_back(e);
      mcount = mcount + int'(acc) - int'(pk);
    end
    #1;
  endtask

  task automatic push(input ent_t e);
    step(e, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popc();
    step(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compares the presented head against the scoreboard front and
  // retires the expected entry whenever a legal pop is being requested.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_empty", 32'(empty_o), 32'(exp_q.size() == 0));
      chk("mon_ready", 32'(ready_o), 32'(exp_q.size() != DEPTH));
      if (exp_q.size() > 0) begin
        chk("mon_res", res_o, exp_q[0].res);
        chk("mon_dest", 32'(dest_o), 32'(exp_q[0].dest));
        chk("mon_flags", {29'd0, wb_o, ld_o, st_o},
            {29'd0, exp_q[0].wb, exp_q[0].ld, exp_q[0].st});
        chk("mon_mdata", md_o, exp_q[0].md);
        chk("mon_size", 32'(sz_o), 32'(exp_q[0].sz));
        chk("mon_bp_valid", 32'(bpv_o),
            32'(exp_q[0].wb && !exp_q[0].ld && exp_q[0].dest != 0));
        if (pop && !flush && !rst) void'(exp_q.pop_front());
      end else begin
        chk("mon_idle_res", res_o, 32'd0);
        chk("mon_idle_bp", 32'(bpv_o), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; valid = 0; pop = 0; flush = 0;
    res_in = 0; dest_in = 0; wb_in = 0; ld_in = 0; st_in = 0; md_in = 0;
    sz_in = 0;
    repeat (2) @(posedge clk);
    #1;
    step(z, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_res", res_o, 32'd0);
    chk("rst_bp", {25'd0, bpv_o, bpd_o}, 32'd0);

    // Single push with forwarding
    push(mk(32'h0000_00FF, 6'd5, 1, 0, 0, 32'h1234, 2'd2));
    chk("single_empty", 32'(empty_o), 32'd0);
    chk("single_res", res_o, 32'hFF);
    chk("single_bpv", 32'(bpv_o), 32'd1);
    chk("single_bpd", 32'(bpd_o), 32'd5);
    chk("single_bpdata", bpdata_o, 32'hFF);
    popc();
    chk("single_drain", 32'(empty_o), 32'd1);

    // Fill and overflow
    push(mk(32'h11, 6'd1, 1, 0, 0, 0, 0));
    push(mk(32'h22, 6'd2, 1, 0, 0, 0, 1));
    chk("full_ready", 32'(ready_o), 32'd0);
    push(mk(32'h33, 6'd3, 1, 0, 0, 0, 2));
    chk("full_head", res_o, 32'h11);
    popc();
    chk("ovf_second", res_o, 32'h22);
    popc();
    chk("ovf_empty", 32'(empty_o), 32'd1);

    // Simultaneous push and pop at count 1
    push(mk(32'hA, 6'd4, 1, 0, 0, 0, 0));
    step(mk(32'hB, 6'd4, 1, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pp_head", res_o, 32'hB);
    chk("pp_ready", 32'(ready_o), 32'd1);
    chk("pp_empty", 32'(empty_o), 32'd0);
    popc();

    // Pop while empty combined with a push
    step(mk(32'h5, 6'd7, 0, 0, 1, 32'hDEAD, 3), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ep_head", res_o, 32'h5);
    chk("ep_bpv", 32'(bpv_o), 32'd0);
    chk("ep_ready", 32'(ready_o), 32'd1);
    popc();

    // Push blocked while full even with a same-cycle pop
    push(mk(32'h61, 6'd1, 1, 0, 0, 0, 0));
    push(mk(32'h62, 6'd2, 1, 0, 0, 0, 0));
    step(mk(32'h66, 6'd6, 1, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fullpp_head", res_o, 32'h62);
    chk("fullpp_ready", 32'(ready_o), 32'd1);
    popc();
    chk("fullpp_empty", 32'(empty_o), 32'd1);

    // Flush overrides a same-cycle push
    push(mk(32'h1, 6'd1, 1, 0, 0, 0, 0));
    push(mk(32'h2, 6'd2, 1, 0, 0, 0, 0));
    step(mk(32'h77, 6'd7, 1, 0, 0, 0, 0), 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_empty", 32'(empty_o), 32'd1);
    chk("flush_ready", 32'(ready_o), 32'd1);
    step(z, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_nostore", 32'(empty_o), 32'd1);

    // Bypass suppression: load, then r0 destination
    push(mk(32'h99, 6'd3, 1, 1, 0, 0, 2));
    push(mk(32'h44, 6'd0, 1, 0, 0, 0, 2));
    chk("bp_load", 32'(bpv_o), 32'd0);
    chk("bp_load_dest", 32'(bpd_o), 32'd0);
    popc();
    chk("bp_r0", 32'(bpv_o), 32'd0);
    chk("bp_r0_data", bpdata_o, 32'd0);
    popc();

    // Load and store both set is stored unchanged
    push(mk(32'hC0DE, 6'd9, 0, 1, 1, 32'hCAFE_F00D, 1));
    chk("ldst_flags", {30'd0, ld_o, st_o}, 32'd3);
    chk("ldst_mdata", md_o, 32'hCAFE_F00D);
    popc();

    // Reset mid-operation wins over flush, push and pop
    push(mk(32'hE1, 6'd1, 1, 0, 0, 0, 0));
    push(mk(32'hE2, 6'd2, 1, 0, 0, 0, 0));
    step(mk(32'hE3, 6'd3, 1, 0, 0, 0, 0), 1'b1, 1'b1, 1'b1, 1'b1);
    chk("mrst_empty", 32'(empty_o), 32'd1);
    chk("mrst_ready", 32'(ready_o), 32'd1);
    chk("mrst_res", res_o, 32'd0);
    chk("mrst_bp", bpdata_o, 32'd0);
    step(z, 1'b0, 1'b0, 1'b0, 1'b0);
    push(mk(32'hF1, 6'd8, 1, 0, 0, 0, 0));
    chk("post_rst_push", res_o, 32'hF1);
    popc();
    step(z, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
